// File: rtl/input_conditioner_if.sv
// input_conditioner_if: raw switch/button inputs and conditioned outputs of the input conditioner
//   master: drives the raw asynchronous inputs, observes the conditioned outputs
//   slave : the conditioner itself
interface input_conditioner_if;
  logic       enable_raw;
  logic       clk_in_raw;
  logic       load_raw;
  logic       up_down_raw;
  logic [7:0] data_raw;
  logic       enable_o;
  logic       up_down_o;
  logic       count_pulse;
  logic       load_pulse;
  logic [7:0] data_o;
  logic       busy;
  modport master (
    output enable_raw, clk_in_raw, load_raw, up_down_raw, data_raw,
    input  enable_o, up_down_o, count_pulse, load_pulse, data_o, busy
  );
  modport slave (
    input  enable_raw, clk_in_raw, load_raw, up_down_raw, data_raw,
    output enable_o, up_down_o, count_pulse, load_pulse, data_o, busy
  );
endinterface

// File: rtl/input_conditioner.sv
// input_conditioner: synchronizes, debounces and edge-detects switch/button inputs for a counter
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : raw inputs in; enable_o/up_down_o levels, count_pulse/load_pulse strobes,
//           data_o preload captured with load_pulse, busy while any debounce is in progress
module input_conditioner #(
  parameter int DEBOUNCE = 15
) (
  input logic                clk,
  input logic                rst_n,
  input_conditioner_if.slave bus
);
  localparam logic [7:0] LIM = 8'(DEBOUNCE - 1);
  // channel bits: 0 enable, 1 clk_in, 2 load, 3 up_down, 11:4 data
  logic [11:0]     meta_q, sync_q;
  logic [3:0][7:0] cnt_q, cnt_d;
  logic [3:0]      stable_q, stable_d, prev_q, rise;
  logic            count_q, count_d, load_q, load_d, busy_q;
  logic [7:0]      data_q, data_d;
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i]    = (sync_q[i] == stable_q[i] || cnt_q[i] == LIM) ? 8'd0 : cnt_q[i] + 8'd1;
      stable_d[i] = (sync_q[i] != stable_q[i] && cnt_q[i] == LIM) ? sync_q[i] : stable_q[i];
    end
  end
  // prev_q lags stable_q by one edge, so rise is high for exactly one cycle per accepted edge
  assign rise    = stable_q & ~prev_q;
  assign load_d  = rise[2] & stable_q[0];
  assign count_d = rise[1] & stable_q[0] & ~rise[2];
  assign data_d  = load_d ? sync_q[11:4] : data_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q   <= '0;
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
      prev_q   <= '0;
      count_q  <= 1'b0;
      load_q   <= 1'b0;
      data_q   <= 8'h00;
      busy_q   <= 1'b0;
    end else begin
      meta_q   <= {bus.data_raw, bus.up_down_raw, bus.load_raw, bus.clk_in_raw, bus.enable_raw};
      sync_q   <= meta_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      prev_q   <= stable_q;
      count_q  <= count_d;
      load_q   <= load_d;
      data_q   <= data_d;
      busy_q   <= |cnt_q;
    end
  end
  assign bus.enable_o    = stable_q[0];
  assign bus.up_down_o   = stable_q[3];
  assign bus.count_pulse = count_q;
  assign bus.load_pulse  = load_q;
  assign bus.data_o      = data_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed self-checking bench for input_conditioner with DEBOUNCE = 4
module tb_input_conditioner;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   passed = 0;
  input_conditioner_if bus ();
  input_conditioner #(.DEBOUNCE(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, "_en"}, {7'd0, bus.enable_o}, 8'd0);
    chk({tag, "_ud"}, {7'd0, bus.up_down_o}, 8'd0);
    chk({tag, "_cnt"}, {7'd0, bus.count_pulse}, 8'd0);
    chk({tag, "_ld"}, {7'd0, bus.load_pulse}, 8'd0);
    chk({tag, "_data"}, bus.data_o, 8'h00);
    chk({tag, "_busy"}, {7'd0, bus.busy}, 8'd0);
  endtask
  initial begin
    int cnts, lds;
    logic saw_busy;
    bus.enable_raw = 0; bus.clk_in_raw = 0; bus.load_raw = 0; bus.up_down_raw = 0; bus.data_raw = 8'h00;
    repeat (3) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    bus.enable_raw = 1;
    repeat (10) tick();
    chk("enable_settled", {7'd0, bus.enable_o}, 8'd1);
    chk("busy_idle", {7'd0, bus.busy}, 8'd0);
    // clean press: strobe exactly after edge 7
    bus.clk_in_raw = 1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("press_cnt_e%0d", k), {7'd0, bus.count_pulse}, {7'd0, k == 7});
      chk($sformatf("press_ld_e%0d", k), {7'd0, bus.load_pulse}, 8'd0);
    end
    bus.clk_in_raw = 0;
    cnts = 0;
    repeat (10) begin tick(); cnts += bus.count_pulse; end
    chk("release_no_strobe", 8'(cnts), 8'd0);
    // glitch shorter than DEBOUNCE
    bus.clk_in_raw = 1;
    repeat (3) tick();
    bus.clk_in_raw = 0;
    cnts = 0; saw_busy = 0;
    repeat (10) begin tick(); cnts += bus.count_pulse; saw_busy |= bus.busy; end
    chk("glitch_no_strobe", 8'(cnts), 8'd0);
    chk("glitch_busy_seen", {7'd0, saw_busy}, 8'd1);
    chk("glitch_busy_done", {7'd0, bus.busy}, 8'd0);
    // load with data capture
    bus.data_raw = 8'hA5; bus.load_raw = 1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("load_e%0d", k), {7'd0, bus.load_pulse}, {7'd0, k == 7});
      if (k == 7) chk("load_data", bus.data_o, 8'hA5);
    end
    bus.load_raw = 0;
    repeat (10) tick();
    bus.data_raw = 8'h3C;
    repeat (10) tick();
    chk("data_hold", bus.data_o, 8'hA5);
    // direction switch
    bus.up_down_raw = 1;
    repeat (10) tick();
    chk("up_down_high", {7'd0, bus.up_down_o}, 8'd1);
    // presses while disabled are dropped
    bus.enable_raw = 0;
    repeat (10) tick();
    chk("enable_low", {7'd0, bus.enable_o}, 8'd0);
    cnts = 0;
    repeat (10) begin
      bus.clk_in_raw = 1;
      repeat (8) begin tick(); cnts += bus.count_pulse; end
      bus.clk_in_raw = 0;
      repeat (8) begin tick(); cnts += bus.count_pulse; end
    end
    chk("disabled_no_strobe", 8'(cnts), 8'd0);
    bus.enable_raw = 1;
    repeat (15) begin tick(); cnts += bus.count_pulse; end
    chk("reenable_no_burst", 8'(cnts), 8'd0);
    chk("reenable_level", {7'd0, bus.enable_o}, 8'd1);
    // simultaneous load and count
    bus.load_raw = 1; bus.clk_in_raw = 1;
    cnts = 0; lds = 0;
    repeat (12) begin tick(); cnts += bus.count_pulse; lds += bus.load_pulse; end
    chk("both_load_once", 8'(lds), 8'd1);
    chk("both_count_never", 8'(cnts), 8'd0);
    bus.load_raw = 0; bus.clk_in_raw = 0;
    repeat (10) tick();
    // reset during a clk_in debounce
    bus.clk_in_raw = 1;
    repeat (3) tick();
    #1 rst_n = 1'b0;
    #1 chk_all_zero("mid_reset");
    bus.clk_in_raw = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    cnts = 0;
    repeat (15) begin tick(); cnts += bus.count_pulse; end
    chk("post_reset_no_strobe", 8'(cnts), 8'd0);
    chk("post_reset_enable", {7'd0, bus.enable_o}, 8'd1);
    // button held through reset counts once
    rst_n = 1'b0;
    bus.clk_in_raw = 1;
    repeat (2) tick();
    rst_n = 1'b1;
    cnts = 0;
    repeat (15) begin tick(); cnts += bus.count_pulse; end
    chk("held_at_reset_once", 8'(cnts), 8'd1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
